dice_game: RTL and testbench
============================

# dice_game

Scorekeeper and turn controller for a two-player "Pig" game played with the electronic dice. It sits downstream of the dice block and shares its `button` input. It watches `button` and the dice's `throw[2:0]` output, and captures the final face when the button is released. It then accumulates turn totals, commits them to per-player scores on `hold`, and declares a winner at a configurable target.

## Interface

Parameters:
- `TARGET`, default 50: score at or above which the committing player wins.
- `SCORE_W`, default 7: width of `turn_total`, `score0` and `score1`. Must satisfy `2**SCORE_W - 1 >= TARGET`.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `button`  in  1  roll button, the same net that drives the dice.
- `throw`  in  3  face from the dice, valid values 1..6.
- `hold`  in  1  one-cycle pulse: current player banks `turn_total`.
- `new_game`  in  1  one-cycle pulse: synchronous restart.
- `player`  out  1  player whose turn it is (0/1).
- `turn_total`  out  SCORE_W  running total of the current turn.
- `score0`, `score1`  out  SCORE_W  banked scores.
- `last_throw`  out  3  last captured face.
- `roll_done`  out  1  one-cycle pulse: a roll was captured.
- `bust`  out  1  one-cycle pulse: a 1 was rolled.
- `game_over`  out  1  high from the win until restart.
- `winner`  out  1  winning player, valid while `game_over` is high.
- `err`  out  1  sticky: an invalid face (0 or 7) was captured.

## Operation

- **States:**
  - IDLE: waiting for a roll or hold.
  - ROLL: button held, dice spinning.
  - OVER: game finished.
- **IDLE:**
  - `hold` high: bank, then check for a win. `hold` has priority over `button` in the same cycle; that cycle's `button` is ignored.
  - Otherwise `button` high: go to ROLL.
- **ROLL:**
  - Stay in ROLL while `button` is high; `hold` is ignored.
  - On the first edge with `button` low, capture `throw` into `last_throw`, pulse `roll_done`, return to IDLE, and evaluate the face:
    - 2..6: `turn_total += throw`, saturating at all-ones.
    - 1: `turn_total <= 0`, `player` toggles, pulse `bust`.
    - 0 or 7: set `err`; `turn_total` and `player` are unchanged.
- **Bank (on `hold` in IDLE):**
  - `score[player] <= sat(score[player] + turn_total)`, then `turn_total <= 0`.
  - If the new score is >= `TARGET`: go to OVER, `winner <= player`, `game_over <= 1`, and `player` does not toggle.
  - Otherwise `player` toggles.
  - Hold with `turn_total` = 0 is legal and simply passes the turn.
- **OVER:** `button` and `hold` are ignored. All outputs are frozen except the pulses, which stay 0.
- **`new_game`**, from any state and with priority over everything except `rst`:
  - Scores, `turn_total`, `player`, `last_throw`, `game_over`, `winner` and `err` are cleared.
  - State goes to IDLE; no roll is captured that cycle.
  - If `button` is still high afterwards, ROLL is entered on the next edge.
- **Arithmetic:** all sums are SCORE_W-bit with saturation, never wrapping. `throw` is zero-extended before adding.

## Timing

- **Reset:** state IDLE; every output is 0, including `player` = 0 and `err` = 0.
- **Entering ROLL:** the first edge sampling `button` = 1 in IDLE enters ROLL.
- **Capture:** happens on the first edge sampling `button` = 0 in ROLL. The dice holds `throw` when `button` is low, so the value sampled at that edge is the final face. All effects of the roll are visible after that same edge; `roll_done`/`bust` are high for exactly that following cycle.
- **Hold:** all effects are visible one cycle after the `hold` edge; `game_over` rises at the same time as the winning score update.
- **Re-roll:** a button pressed again the cycle after release is legal, giving a minimum of 2 cycles between captures (one IDLE cycle).
- **Async reset mid-ROLL:** the in-flight roll is discarded and no `roll_done` is produced.
- **Pulse width:** `hold` and `new_game` wider than one cycle behave as repeated pulses. `hold` repeated in IDLE banks 0 for the new player and passes the turn again.

## Test plan

- **Reset:** assert `rst` mid-ROLL with `throw` = 5 → all outputs 0, state IDLE, no `roll_done`.
- **Accumulate then bank:** player 0 rolls 4 then 6 → `turn_total` = 10. `hold` → `score0` = 10, `turn_total` = 0, `player` = 1.
- **Bust:** player 1 rolls 3, then rolls 1 → `bust` pulses once, `turn_total` = 0, `player` = 0, `score1` unchanged.
- **Win:** with `TARGET` = 20, `score0` = 15, player 0 rolls 5 and holds → `score0` = 20, `game_over` = 1, `winner` = 0. Later `button`/`hold` cause no change. `new_game` → all scores 0, IDLE.
- **Priority:** `hold` and `button` both high in IDLE → bank occurs and state stays IDLE that cycle. With `button` still high, the next edge enters ROLL.
- **Invalid face:** force `throw` = 7 at release → `err` = 1 (sticky), `roll_done` pulses, `turn_total` and `player` unchanged. `err` clears only on `new_game`/`rst`.

Source files
------------

// File: rtl/dice_game.sv
// Pig scorekeeper and turn controller: captures the dice face on button release,
// accumulates turn totals, banks them on hold and declares a winner at TARGET.
module dice_game #(
  parameter int unsigned TARGET  = 50,
  parameter int unsigned SCORE_W = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               button,
  input  logic [2:0]         throw,
  input  logic               hold,
  input  logic               new_game,
  output logic               player,
  output logic [SCORE_W-1:0] turn_total,
  output logic [SCORE_W-1:0] score0,
  output logic [SCORE_W-1:0] score1,
  output logic [2:0]         last_throw,
  output logic               roll_done,
  output logic               bust,
  output logic               game_over,
  output logic               winner,
  output logic               err
);

  localparam logic [SCORE_W:0] TGT = (SCORE_W+1)'(TARGET);

  typedef enum logic [1:0] {IDLE, ROLL, OVER} state_t;

  state_t             state_q, state_d;
  logic               player_q, player_d;
  logic [SCORE_W-1:0] tt_q, tt_d;
  logic [SCORE_W-1:0] s0_q, s0_d;
  logic [SCORE_W-1:0] s1_q, s1_d;
  logic [2:0]         last_q, last_d;
  logic               rd_q, rd_d;
  logic               bust_q, bust_d;
  logic               go_q, go_d;
  logic               win_q, win_d;
  logic               err_q, err_d;
  logic [SCORE_W-1:0] bank_sum;

  // Saturating SCORE_W-bit add
  function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                  input logic [SCORE_W-1:0] b);
    logic [SCORE_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[SCORE_W] ? {SCORE_W{1'b1}} : s[SCORE_W-1:0];
  endfunction

  assign bank_sum = sat_add(player_q ? s1_q : s0_q, tt_q);

  always_comb begin
    state_d  = state_q;
    player_d = player_q;
    tt_d     = tt_q;
    s0_d     = s0_q;
    s1_d     = s1_q;
    last_d   = last_q;
    rd_d     = 1'b0;
    bust_d   = 1'b0;
    go_d     = go_q;
    win_d    = win_q;
    err_d    = err_q;

    if (new_game) begin
      state_d  = IDLE;
      player_d = 1'b0;
      tt_d     = '0;
      s0_d     = '0;
      s1_d     = '0;
      last_d   = '0;
      go_d     = 1'b0;
      win_d    = 1'b0;
      err_d    = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (hold) begin
            if (player_q) s1_d = bank_sum;
            else          s0_d = bank_sum;
            tt_d = '0;
            if ({1'b0, bank_sum} >= TGT) begin
              state_d = OVER;
              go_d    = 1'b1;
              win_d   = player_q;
            end else begin
              player_d = ~player_q;
            end
          end else if (button) begin
            state_d = ROLL;
          end
        end
        ROLL: begin
          if (!button) begin
            state_d = IDLE;
            last_d  = throw;
            rd_d    = 1'b1;
            case (throw)
              3'd1: begin
                tt_d     = '0;
                player_d = ~player_q;
                bust_d   = 1'b1;
              end
              3'd0, 3'd7: err_d = 1'b1;
              default:    tt_d  = sat_add(tt_q, SCORE_W'(throw));
            endcase
          end
        end
        OVER:    state_d = OVER;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      player_q <= 1'b0;
      tt_q     <= '0;
      s0_q     <= '0;
      s1_q     <= '0;
      last_q   <= '0;
      rd_q     <= 1'b0;
      bust_q   <= 1'b0;
      go_q     <= 1'b0;
      win_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      player_q <= player_d;
      tt_q     <= tt_d;
      s0_q     <= s0_d;
      s1_q     <= s1_d;
      last_q   <= last_d;
      rd_q     <= rd_d;
      bust_q   <= bust_d;
      go_q     <= go_d;
      win_q    <= win_d;
      err_q    <= err_d;
    end
  end

  assign player     = player_q;
  assign turn_total = tt_q;
  assign score0     = s0_q;
  assign score1     = s1_q;
  assign last_throw = last_q;
  assign roll_done  = rd_q;
  assign bust       = bust_q;
  assign game_over  = go_q;
  assign winner     = win_q;
  assign err        = err_q;

endmodule

// File: tb/tb_dice_game.sv
// Randomized bench for dice_game against a game-rule reference model (TARGET = 20).
module tb_dice_game;

  localparam int unsigned TARGET  = 20;
  localparam int unsigned SCORE_W = 7;
  localparam int          MAXV    = (1 << SCORE_W) - 1;

  logic               clk = 1'b0;
  logic               rst;
  logic               button;
  logic [2:0]         throw;
  logic               hold;
  logic               new_game;
  logic               player;
  logic [SCORE_W-1:0] turn_total;
  logic [SCORE_W-1:0] score0;
  logic [SCORE_W-1:0] score1;
  logic [2:0]         last_throw;
  logic               roll_done;
  logic               bust;
  logic               game_over;
  logic               winner;
  logic               err;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int m_score[2];
  int m_tt, m_p, m_last, m_go, m_win, m_err;

  dice_game #(.TARGET(TARGET), .SCORE_W(SCORE_W)) dut (
    .clk(clk), .rst(rst), .button(button), .throw(throw), .hold(hold),
    .new_game(new_game), .player(player), .turn_total(turn_total),
    .score0(score0), .score1(score1), .last_throw(last_throw),
    .roll_done(roll_done), .bust(bust), .game_over(game_over),
    .winner(winner), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all(input int exp_rd, input int exp_bust);
    check("player",     int'(player),     m_p);
    check("turn_total", int'(turn_total), m_tt);
    check("score0",     int'(score0),     m_score[0]);
    check("score1",     int'(score1),     m_score[1]);
    check("last_throw", int'(last_throw), m_last);
    check("roll_done",  int'(roll_done),  exp_rd);
    check("bust",       int'(bust),       exp_bust);
    check("game_over",  int'(game_over),  m_go);
    check("winner",     int'(winner),     m_win);
    check("err",        int'(err),        m_err);
  endtask

  task automatic model_clear();
    m_score[0] = 0; m_score[1] = 0;
    m_tt = 0; m_p = 0; m_last = 0; m_go = 0; m_win = 0; m_err = 0;
  endtask

  task automatic model_bank();
    int s;
    if (m_go != 0) return;
    s = m_score[m_p] + m_tt;
    if (s > MAXV) s = MAXV;
    m_score[m_p] = s;
    m_tt = 0;
    if (s >= int'(TARGET)) begin
      m_go = 1;
      m_win = m_p;
    end else begin
      m_p ^= 1;
    end
  endtask

  // Called from a falling edge; button high for n rising edges, then released with face
  task automatic do_roll(input int face, input int n);
    int rd, bu;
    button = 1'b1;
    repeat (n) begin
      throw = 3'($urandom_range(0, 7));
      @(negedge clk);
    end
    button = 1'b0;
    throw  = 3'(face);
    @(negedge clk);
    rd = 0; bu = 0;
    if (m_go == 0) begin
      rd = 1;
      m_last = face;
      if (face == 1) begin
        m_tt = 0; m_p ^= 1; bu = 1;
      end else if (face == 0 || face == 7) begin
        m_err = 1;
      end else begin
        m_tt = (m_tt + face > MAXV) ? MAXV : m_tt + face;
      end
    end
    check_all(rd, bu);
  endtask

  task automatic do_hold(input int n);
    hold = 1'b1;
    repeat (n) begin
      @(negedge clk);
      model_bank();
    end
    hold = 1'b0;
    check_all(0, 0);
  endtask

  task automatic do_new_game();
    new_game = 1'b1;
    @(negedge clk);
    new_game = 1'b0;
    model_clear();
    check_all(0, 0);
  endtask

  initial begin
    int r, face;
    rst = 1'b1; button = 1'b0; throw = 3'd0; hold = 1'b0; new_game = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    check_all(0, 0);
    rst = 1'b0;
    @(negedge clk);
    check_all(0, 0);

    // Async reset while a roll is in flight
    do_roll(3, 1);
    button = 1'b1; throw = 3'd5;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1 model_clear();
    check_all(0, 0);
    @(negedge clk);
    button = 1'b0; rst = 1'b0;
    @(negedge clk);
    check_all(0, 0);

    // Accumulate then bank
    do_roll(4, 2);
    do_roll(6, 1);
    check("tt_after_4_6", int'(turn_total), 10);
    do_hold(1);
    check("score0_bank", int'(score0), 10);

    // Bust for player 1
    do_roll(3, 3);
    do_roll(1, 1);
    check("player_after_bust", int'(player), 0);

    // hold beats button; button still high enters ROLL on the next edge
    do_roll(2, 1);
    hold = 1'b1; button = 1'b1;
    @(negedge clk);
    hold = 1'b0;
    model_bank();
    check_all(0, 0);
    do_roll(5, 1);

    // Win at TARGET exactly, then frozen
    do_new_game();
    do_roll(5, 1); do_roll(5, 1); do_roll(5, 1);
    do_hold(1);
    do_hold(1);
    do_roll(5, 2);
    do_hold(1);
    check("win_score0", int'(score0), 20);
    check("win_flag", int'(game_over), 1);
    do_roll(6, 2);
    do_hold(2);
    do_new_game();

    // Invalid faces are sticky
    do_roll(7, 1);
    do_roll(4, 1);
    do_roll(0, 2);
    check("err_sticky", int'(err), 1);
    do_new_game();

    // Saturation of turn_total and score
    for (int i = 0; i < 22; i++) do_roll(6, 1);
    check("tt_sat", int'(turn_total), MAXV);
    do_hold(1);
    do_new_game();

    // Wide hold passes the turn repeatedly
    do_hold(3);
    check("wide_hold_player", int'(player), 1);

    // new_game with button held, then ROLL on the following edge
    button = 1'b1; new_game = 1'b1;
    @(negedge clk);
    new_game = 1'b0;
    model_clear();
    check_all(0, 0);
    do_roll(4, 1);

    // Randomized play
    for (int i = 0; i < 300; i++) begin
      r = int'($urandom_range(0, 9));
      if (r <= 5) begin
        face = ($urandom_range(0, 9) == 0) ? (($urandom_range(0, 1) == 0) ? 0 : 7)
                                            : int'($urandom_range(1, 6));
        do_roll(face, int'($urandom_range(1, 3)));
      end else if (r == 9 && (m_go != 0 || $urandom_range(0, 3) == 0)) begin
        do_new_game();
      end else begin
        do_hold(int'($urandom_range(1, 2)));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
